seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Parametrised multiplexed 7-segment display controller, successor to the fixed 8-digit scanner used on the board display. It holds a double-buffered display image loaded by a strobe, generates its own scan rate from the system clock, applies per-frame brightness PWM with an anti-ghosting dead cycle, and drives active-low anode and cathode lines. It sits between the sequence-analyzer result logic and the board pins.

## Interface
- N_DIG, 8, number of digits (2..8)
- SCAN_DIV, 100000, clock cycles per digit slot; multiple of 2^BRIGHT_W, at least 2*2^BRIGHT_W
- BRIGHT_W, 4, brightness code width
- CLK_100  in  1  system clock, 100 MHz
- RST_N  in  1  reset, asynchronous, active-low
- HEX_IN  in  4*N_DIG  digit codes, digit k = HEX_IN[4k+3:4k], digit 0 rightmost
- BLANK  in  N_DIG  1 = digit dark
- DP_IN  in  N_DIG  1 = decimal point lit
- LOAD  in  1  one-cycle strobe: capture HEX_IN/BLANK/DP_IN into shadow
- BRIGHT  in  BRIGHT_W  duty code, sampled every cycle
- AN  out  N_DIG  anodes, active-low, one-hot-low or all high
- CAT  out  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}
- FRAME  out  1  one-cycle pulse at frame wrap
- PENDING  out  1  shadow holds an image not yet displayed

## Operation
- Prescaler pre_cnt counts 0..SCAN_DIV-1; at terminal count dig_idx advances, N_DIG-1 wraps to 0.
- Frame wrap (pre_cnt terminal and dig_idx = N_DIG-1): FRAME=1 that cycle; if PENDING, active image <= shadow and PENDING clears.
- LOAD: shadow <= inputs, PENDING sets. LOAD while PENDING overwrites shadow. LOAD on the wrap cycle: swap takes old shadow, new data captured, PENDING stays 1.
- Slot split into 2^BRIGHT_W subslots of SUB = SCAN_DIV/2^BRIGHT_W cycles; sub_idx = pre_cnt/SUB.
- Digit lit when: pre_cnt != 0 (dead cycle), sub_idx <= BRIGHT, active BLANK bit 0, not suppressed.
- Lit: AN bit dig_idx low, others high; CAT = ~{dp, seg}. Not lit: AN all high, CAT = 8'hFF.
- seg from hex glyphs, {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.

## Timing
- AN, CAT registered: reflect pre_cnt/dig_idx/active image of previous cycle (1-cycle latency).
- New image first visible on the cycle after the wrap cycle's dead cycle, i.e. AN low at wrap+2.
- Reset values: AN all ones, CAT 8'hFF, FRAME 0, PENDING 0, pre_cnt 0, dig_idx 0, active and shadow BLANK all ones, HEX/DP zero. Display stays dark until first LOAD reaches a frame wrap.
- RST_N low mid-frame: all outputs to reset values immediately (asynchronous); pending LOAD lost.
- BRIGHT change takes effect next cycle, no frame alignment.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero suppression. Digit k>0 suppressed if its code is 0, its DP bit is 0, and every digit above k is suppressed or BLANK; digit 0 never suppressed. Computed from the active image.
- Undefined: zeros display normally; no suppression logic present.

## Structure
- Package seg_pkg: glyph constants, CAT_OFF (8'hFF), AN_OFF helper, default N_DIG/SCAN_DIV/BRIGHT_W.
- Sub-module seg7_decode: combinational 4-bit code -> 7-bit active-high segments, glyphs above.
- Top holds prescaler, digit counter, shadow/active registers, suppression mask, output registers.

## Test plan
- Reset: RST_N low for 3 cycles, then 2 frames without LOAD -> AN all ones, CAT 8'hFF, FRAME pulses once per N_DIG*SCAN_DIV cycles.
- N_DIG=4, SCAN_DIV=32, BRIGHT=15: LOAD 16'h1234, BLANK=0, DP=0 -> after wrap, digit 0 AN=4'b1110 CAT=8'h99; digit 3 AN=4'b0111 CAT=8'hF9; each lit 31 cycles per slot.
- BRIGHT=0, SCAN_DIV=32, BRIGHT_W=4 -> AN low exactly 1 cycle (pre_cnt=1) per slot; BRIGHT=7 -> 15 cycles.
- LOAD mid-frame -> display unchanged, PENDING=1 until FRAME, new image next frame; LOAD on wrap cycle -> older shadow shown, PENDING remains 1.
- SEG_LZ_BLANK_EN, HEX=16'h0005, DP=0 -> digits 3..1 dark, digit 0 CAT=8'h92; DP_IN=4'b0100 -> digit 3 dark, digit 2 shows "0." (CAT=8'h40), digit 1 shows 0.
- RST_N low during a lit slot -> same-cycle AN all ones, PENDING 0; after release display dark until new LOAD plus wrap.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: glyph table,
// inactive cathode/anode levels and default geometry.
package seg_pkg;

    localparam int DEF_N_DIG    = 8;
    localparam int DEF_SCAN_DIV = 100000;
    localparam int DEF_BRIGHT_W = 4;

    localparam logic [7:0] CAT_OFF = 8'hFF;
    localparam logic       AN_OFF  = 1'b1;

    // Active-high segments {g,f,e,d,c,b,a}, indexed by the hex code.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic an_level(input int k, input int sel, input logic lit);
        return (lit && (k == sel)) ? ~AN_OFF : AN_OFF;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-code to active-high 7-segment glyph decoder.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPH[code_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment controller: double-buffered image, scan prescaler,
// brightness PWM with dead cycle. Define SEG_LZ_BLANK_EN for leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIG    = DEF_N_DIG,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int BRIGHT_W = DEF_BRIGHT_W
) (
    input  logic                 CLK_100,
    input  logic                 RST_N,
    input  logic [4*N_DIG-1:0]   HEX_IN,
    input  logic [N_DIG-1:0]     BLANK,
    input  logic [N_DIG-1:0]     DP_IN,
    input  logic                 LOAD,
    input  logic [BRIGHT_W-1:0]  BRIGHT,
    output logic [N_DIG-1:0]     AN,
    output logic [7:0]           CAT,
    output logic                 FRAME,
    output logic                 PENDING
);

    localparam int SUB   = SCAN_DIV / (2 ** BRIGHT_W);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int SUB_W = $clog2(SUB);
    localparam int DIG_W = $clog2(N_DIG);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
    logic [BRIGHT_W-1:0] sub_idx_q, sub_idx_d;
    logic [DIG_W-1:0]    dig_idx_q, dig_idx_d;
    logic                slot_end, wrap;

    logic [4*N_DIG-1:0]  hex_sh_q, hex_act_q;
    logic [N_DIG-1:0]    blank_sh_q, blank_act_q;
    logic [N_DIG-1:0]    dp_sh_q, dp_act_q;
    logic                pending_q, pending_d;

    logic [N_DIG-1:0]    supp_mask;
    logic [3:0]          cur_code;
    logic [6:0]          cur_seg;
    logic                cur_blank, cur_dp, cur_supp, lit;

    logic [N_DIG-1:0]    an_q, an_d;
    logic [7:0]          cat_q, cat_d;

    assign slot_end = (pre_cnt_q == PRE_W'(SCAN_DIV - 1));
    assign wrap     = slot_end && (dig_idx_q == DIG_W'(N_DIG - 1));

    // Subslot index is tracked with its own counter so no divider is needed
    // for SUB values that are not powers of two.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        sub_cnt_d = sub_cnt_q + SUB_W'(1);
        sub_idx_d = sub_idx_q;
        dig_idx_d = dig_idx_q;
        if (slot_end) begin
            pre_cnt_d = '0;
            sub_cnt_d = '0;
            sub_idx_d = '0;
            dig_idx_d = wrap ? '0 : dig_idx_q + DIG_W'(1);
        end else if (sub_cnt_q == SUB_W'(SUB - 1)) begin
            sub_cnt_d = '0;
            sub_idx_d = sub_idx_q + BRIGHT_W'(1);
        end
    end

    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            pre_cnt_q <= '0;
            sub_cnt_q <= '0;
            sub_idx_q <= '0;
            dig_idx_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            sub_cnt_q <= sub_cnt_d;
            sub_idx_q <= sub_idx_d;
            dig_idx_q <= dig_idx_d;
        end
    end

    // A LOAD coinciding with the wrap re-arms PENDING: the swap takes the old shadow.
    always_comb begin
        pending_d = pending_q;
        if (LOAD)
            pending_d = 1'b1;
        else if (wrap)
            pending_d = 1'b0;
    end

    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            hex_sh_q    <= '0;
            blank_sh_q  <= '1;
            dp_sh_q     <= '0;
            hex_act_q   <= '0;
            blank_act_q <= '1;
            dp_act_q    <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (LOAD) begin
                hex_sh_q   <= HEX_IN;
                blank_sh_q <= BLANK;
                dp_sh_q    <= DP_IN;
            end
            if (wrap && pending_q) begin
                hex_act_q   <= hex_sh_q;
                blank_act_q <= blank_sh_q;
                dp_act_q    <= dp_sh_q;
            end
            pending_q <= pending_d;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // Walk down from the most significant digit; a zero stays dark only while
    // everything above it is dark too.
    always_comb begin
        logic above_dark;
        above_dark = 1'b1;
        supp_mask  = '0;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            supp_mask[k] = above_dark && (hex_act_q[4*k +: 4] == 4'h0) && !dp_act_q[k];
            above_dark   = above_dark && (supp_mask[k] || blank_act_q[k]);
        end
    end
`else
    assign supp_mask = '0;
`endif

    assign cur_code  = hex_act_q[{dig_idx_q, 2'b00} +: 4];
    assign cur_blank = blank_act_q[dig_idx_q];
    assign cur_dp    = dp_act_q[dig_idx_q];
    assign cur_supp  = supp_mask[dig_idx_q];

    seg7_decode u_decode (
        .code_i (cur_code),
        .seg_o  (cur_seg)
    );

    // pre_cnt == 0 is the anti-ghosting dead cycle between digits.
    assign lit = (pre_cnt_q != '0) && (sub_idx_q <= BRIGHT) && !cur_blank && !cur_supp;

    always_comb begin
        an_d = '1;
        for (int k = 0; k < N_DIG; k++)
            an_d[k] = an_level(k, int'(dig_idx_q), lit);
        cat_d = lit ? ~{cur_dp, cur_seg} : CAT_OFF;
    end

    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            an_q  <= '1;
            cat_q <= CAT_OFF;
        end else begin
            an_q  <= an_d;
            cat_q <= cat_d;
        end
    end

    assign AN      = an_q;
    assign CAT     = cat_q;
    assign FRAME   = wrap;
    assign PENDING = pending_q;

endmodule
